// File: rtl/mmcm_reset_ctrl.sv
// MMCM reset sequencer: hold, wait for lock, settle, run, with retry/fault.
// Optional macro MMCM_PWRDWN_EN drives mmcm_pwrdwn high while in FAULT.
module mmcm_reset_ctrl #(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int LOCK_TIMEOUT    = 65535,
    parameter int SETTLE_CYCLES   = 256,
    parameter int MAX_RETRIES     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mmcm_locked,
    input  logic       restart,
    output logic       mmcm_rst,
    output logic       mmcm_pwrdwn,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [7:0] lock_loss_cnt
);

    localparam int HW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam int WW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [HW-1:0] HOLD_LAST   = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST   = WW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

`ifdef MMCM_PWRDWN_EN
    localparam logic PWR_ON = 1'b1;
`else
    localparam logic PWR_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_SETTLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          locked_s;
    logic [HW-1:0] hold_cnt;
    logic [WW-1:0] wait_cnt;
    logic [SW-1:0] settle_cnt;
    logic [3:0]    retry_cnt;

    assign locked_s = sync[1];

    // Bring the asynchronous LOCKED into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], mmcm_locked};
        end
    end

    // Sequencer FSM; every output is a flop updated on state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_HOLD;
            hold_cnt      <= '0;
            wait_cnt      <= '0;
            settle_cnt    <= '0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
            mmcm_rst      <= 1'b1;
            mmcm_pwrdwn   <= 1'b0;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else if (restart) begin
            state       <= S_HOLD;
            hold_cnt    <= '0;
            retry_cnt   <= '0;
            mmcm_rst    <= 1'b1;
            mmcm_pwrdwn <= 1'b0;
            sys_rst_n   <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            unique case (state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= S_WAIT_LOCK;
                        wait_cnt <= '0;
                        mmcm_rst <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        // The detecting cycle is the first settle cycle.
                        if (SETTLE_CYCLES == 1) begin
                            state     <= S_RUN;
                            sys_rst_n <= 1'b1;
                            ready     <= 1'b1;
                            retry_cnt <= '0;
                        end else begin
                            state      <= S_SETTLE;
                            settle_cnt <= SW'(1);
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        if (retry_cnt == RETRY_MAX) begin
                            state       <= S_FAULT;
                            mmcm_rst    <= 1'b1;
                            mmcm_pwrdwn <= PWR_ON;
                            fault       <= 1'b1;
                        end else begin
                            state     <= S_HOLD;
                            hold_cnt  <= '0;
                            retry_cnt <= retry_cnt + 1'b1;
                            mmcm_rst  <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (!locked_s) begin
                        state    <= S_HOLD;
                        hold_cnt <= '0;
                        mmcm_rst <= 1'b1;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state     <= S_RUN;
                        sys_rst_n <= 1'b1;
                        ready     <= 1'b1;
                        retry_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state     <= S_HOLD;
                        hold_cnt  <= '0;
                        mmcm_rst  <= 1'b1;
                        sys_rst_n <= 1'b0;
                        ready     <= 1'b0;
                        if (lock_loss_cnt != 8'hFF) begin
                            lock_loss_cnt <= lock_loss_cnt + 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    // Parked until restart or rst_n.
                end
                default: begin
                    state       <= S_HOLD;
                    hold_cnt    <= '0;
                    mmcm_rst    <= 1'b1;
                    mmcm_pwrdwn <= 1'b0;
                    sys_rst_n   <= 1'b0;
                    ready       <= 1'b0;
                    fault       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_reset_ctrl.sv
// Directed bench for mmcm_reset_ctrl with small parameters.
// Covers nominal bring-up, settle glitch, timeout/fault, lock loss, async reset.
module tb_mmcm_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mmcm_locked;
    logic       restart;
    logic       mmcm_rst;
    logic       mmcm_pwrdwn;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] lock_loss_cnt;

    int total = 0;
    int bad   = 0;
    int n;

`ifdef MMCM_PWRDWN_EN
    localparam int PWR_EXP = 1;
`else
    localparam int PWR_EXP = 0;
`endif

    mmcm_reset_ctrl #(
        .RST_HOLD_CYCLES(4),
        .LOCK_TIMEOUT   (20),
        .SETTLE_CYCLES  (8),
        .MAX_RETRIES    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mmcm_locked  (mmcm_locked),
        .restart      (restart),
        .mmcm_rst     (mmcm_rst),
        .mmcm_pwrdwn  (mmcm_pwrdwn),
        .sys_rst_n    (sys_rst_n),
        .ready        (ready),
        .fault        (fault),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Wait for mmcm_rst high, then count negedges until it falls.
    task automatic hold_len(output int cnt);
        int guard = 0;
        while (!mmcm_rst && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        cnt = 0;
        while (mmcm_rst && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    // Count negedges while mmcm_rst stays low.
    task automatic low_len(output int cnt);
        cnt = 0;
        while (!mmcm_rst && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic wait_sys_low(output int cnt);
        cnt = 0;
        while (sys_rst_n && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        mmcm_locked = 1'b0;
        restart     = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_mmcm_rst", mmcm_rst, 1);
        chk("rst_pwrdwn", mmcm_pwrdwn, 0);
        chk("rst_sys_rst_n", sys_rst_n, 0);
        chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0);
        chk("rst_loss", lock_loss_cnt, 0);

        // Nominal bring-up.
        rst_n = 1'b1;
        hold_len(n);
        chk("nom_hold", n, 4);
        repeat (5) @(negedge clk);
        mmcm_locked = 1'b1;
        wait_ready(n);
        chk("nom_lock2ready", n, 10);
        chk("nom_sys_rst_n", sys_rst_n, 1);
        chk("nom_mmcm_rst", mmcm_rst, 0);

        // Lock loss while running, three times with re-lock.
        for (int i = 0; i < 3; i++) begin
            mmcm_locked = 1'b0;
            wait_sys_low(n);
            chk("loss_lat", n, 3);
            chk("loss_ready", ready, 0);
            chk("loss_mmcm_rst", mmcm_rst, 1);
            mmcm_locked = 1'b1;
            wait_ready(n);
            chk("relock_ready", ready, 1);
        end
        chk("loss_cnt", lock_loss_cnt, 3);

        // Restart beats the simultaneous lock drop.
        restart     = 1'b1;
        mmcm_locked = 1'b0;
        @(negedge clk);
        restart = 1'b0;
        chk("rs_ready", ready, 0);
        chk("rs_sys_rst_n", sys_rst_n, 0);
        chk("rs_mmcm_rst", mmcm_rst, 1);
        chk("rs_loss_kept", lock_loss_cnt, 3);

        // Settle glitch: high 5, low 1, high.
        hold_len(n);
        chk("gl_hold1", n, 4);
        mmcm_locked = 1'b1;
        repeat (5) @(negedge clk);
        mmcm_locked = 1'b0;
        @(negedge clk);
        mmcm_locked = 1'b1;
        hold_len(n);
        chk("gl_hold2", n, 4);
        chk("gl_no_ready", ready, 0);
        chk("gl_retry", dut.retry_cnt, 0);
        wait_ready(n);
        chk("gl_ready", ready, 1);

        // Timeout path: lock never returns.
        mmcm_locked = 1'b0;
        wait_sys_low(n);
        chk("to_loss_cnt", lock_loss_cnt, 4);
        for (int i = 0; i < 3; i++) begin
            hold_len(n);
            chk($sformatf("to_hold%0d", i), n, 4);
            low_len(n);
            chk($sformatf("to_win%0d", i), n, 20);
        end
        chk("flt_fault", fault, 1);
        chk("flt_mmcm_rst", mmcm_rst, 1);
        chk("flt_sys_rst_n", sys_rst_n, 0);
        chk("flt_pwrdwn", mmcm_pwrdwn, PWR_EXP);
        repeat (30) @(negedge clk);
        chk("flt_stays", fault, 1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("flt_rs_fault", fault, 0);
        chk("flt_rs_pwrdwn", mmcm_pwrdwn, 0);
        chk("flt_rs_mmcm_rst", mmcm_rst, 1);

        // Async reset in the middle of SETTLE.
        hold_len(n);
        chk("ar_hold", n, 4);
        mmcm_locked = 1'b1;
        repeat (5) @(negedge clk);
        chk("ar_pre_mmcm_rst", mmcm_rst, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_mmcm_rst", mmcm_rst, 1);
        chk("ar_loss", lock_loss_cnt, 0);
        chk("ar_sys_rst_n", sys_rst_n, 0);
        chk("ar_ready", ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hold_len(n);
        chk("ar_hold2", n, 4);
        wait_ready(n);
        chk("ar_settle", n, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
